// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single-port 8 KiB character/font memory between the VGA text
// fetch engine (fixed priority) and the host write/readback port. The host
// is guaranteed a slot after STARVE_MAX consecutive denied cycles, and host
// writes into the font region can be dropped by a write-protect input.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_vid_req/i_vid_addr           video read request and address
//   o_vid_stall                    video not granted this cycle, hold request
//   o_vid_valid/o_vid_dat          video read data, one cycle after grant
//   i_host_req/we/addr/dat         host request, held until o_host_ack
//   o_host_ack/o_host_dat          one-cycle completion pulse, read data
//   o_host_err                     write dropped by font write-protect
//   i_font_wp                      drop host writes below FONT_TOP
//   o_mem_cs/we/addr/dat           memory-side drive (combinational)
//   i_mem_dat                      memory read data, one-cycle latency

module mem_arbiter #(
    parameter int AW         = 13,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 15,
    parameter int FONT_TOP   = 'h1000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_vid_req,
    input  logic [AW-1:0] i_vid_addr,
    output logic          o_vid_stall,
    output logic          o_vid_valid,
    output logic [DW-1:0] o_vid_dat,
    input  logic          i_host_req,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_dat,
    output logic          o_host_ack,
    output logic [DW-1:0] o_host_dat,
    output logic          o_host_err,
    input  logic          i_font_wp,
    output logic          o_mem_cs,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_dat,
    input  logic [DW-1:0] i_mem_dat
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    localparam logic [7:0]  STARVE_MAX_C = 8'(STARVE_MAX);
    localparam logic [31:0] FONT_TOP_C   = 32'(FONT_TOP);

    // True when the address falls inside the protected font region.
    function automatic logic font_hit(input logic [AW-1:0] addr);
        logic [31:0] addr_ext;
        addr_ext = 32'(addr);
        return (addr_ext < FONT_TOP_C);
    endfunction

    owner_e        owner_s;
    owner_e        rd_owner_q, rd_owner_d;
    logic          host_elig_s;
    logic          prot_hit_s;
    logic          host_busy_q, host_busy_d;
    logic          rd_wr_q, rd_wr_d;
    logic          rd_prot_q, rd_prot_d;
    logic [7:0]    starve_cnt_q, starve_cnt_d;

    // Owner selection for the current grant cycle; reset forces NONE so the
    // memory is never selected or written while i_rst_n is low.
    always_comb begin
        host_elig_s = i_host_req & ~host_busy_q;
        prot_hit_s  = i_font_wp & font_hit(i_host_addr);
        owner_s     = OWN_NONE;
        if (!i_rst_n) begin
            owner_s = OWN_NONE;
        end else if (host_elig_s && (starve_cnt_q == STARVE_MAX_C)) begin
            owner_s = OWN_HOST;
        end else if (i_vid_req) begin
            owner_s = OWN_VID;
        end else if (host_elig_s) begin
            owner_s = OWN_HOST;
        end else begin
            owner_s = OWN_NONE;
        end
    end

    // Memory-side drive and video stall, combinational from the owner.
    always_comb begin
        o_mem_cs    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = {AW{1'b0}};
        o_mem_dat   = {DW{1'b0}};
        o_vid_stall = i_rst_n & i_vid_req & (owner_s != OWN_VID);
        case (owner_s)
            OWN_VID: begin
                o_mem_cs   = 1'b1;
                o_mem_addr = i_vid_addr;
            end
            OWN_HOST: begin
                o_mem_cs   = 1'b1;
                o_mem_addr = i_host_addr;
                if (i_host_we) begin
                    // A protected write still takes the slot but never strobes we.
                    o_mem_we  = ~prot_hit_s;
                    o_mem_dat = i_host_dat;
                end else begin
                    o_mem_we  = 1'b0;
                end
            end
            default: begin
                o_mem_cs = 1'b0;
            end
        endcase
    end

    // Next-state for the starvation counter, busy guard and response tag.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        host_busy_d  = host_busy_q;
        rd_owner_d   = owner_s;
        rd_wr_d      = (owner_s == OWN_HOST) & i_host_we;
        rd_prot_d    = (owner_s == OWN_HOST) & i_host_we & prot_hit_s;
        if (owner_s == OWN_HOST) begin
            starve_cnt_d = 8'd0;
        end else if (host_elig_s && (starve_cnt_q < STARVE_MAX_C)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
        // Busy spans grant edge through the end of the ack cycle, which blocks
        // a re-grant while the host still sees its own ack.
        if (owner_s == OWN_HOST) begin
            host_busy_d = 1'b1;
        end else if (rd_owner_q == OWN_HOST) begin
            host_busy_d = 1'b0;
        end else begin
            host_busy_d = host_busy_q;
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt_q <= 8'd0;
            host_busy_q  <= 1'b0;
            rd_owner_q   <= OWN_NONE;
            rd_wr_q      <= 1'b0;
            rd_prot_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            host_busy_q  <= host_busy_d;
            rd_owner_q   <= rd_owner_d;
            rd_wr_q      <= rd_wr_d;
            rd_prot_q    <= rd_prot_d;
        end
    end

    // Response decode one cycle after grant; data buses are zero unless valid.
    always_comb begin
        o_vid_valid = (rd_owner_q == OWN_VID);
        o_host_ack  = (rd_owner_q == OWN_HOST);
        o_host_err  = o_host_ack & rd_wr_q & rd_prot_q;
        if (o_vid_valid) begin
            o_vid_dat = i_mem_dat;
        end else begin
            o_vid_dat = {DW{1'b0}};
        end
        if (o_host_ack && !rd_wr_q) begin
            o_host_dat = i_mem_dat;
        end else begin
            o_host_dat = {DW{1'b0}};
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency memory.
// Expected read data is queued at stimulus time; a negedge monitor pops and
// compares whenever the DUT presents video data or a host ack.

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [12:0] vid_addr = 13'h0;
    logic        vid_stall, vid_valid;
    logic [7:0]  vid_dat;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [12:0] host_addr = 13'h0;
    logic [7:0]  host_wdat = 8'h0;
    logic        host_ack, host_err;
    logic [7:0]  host_rdat;
    logic        font_wp = 1'b0;
    logic        mem_cs, mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdat;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem [0:8191];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  vid_exp [$];
    logic [8:0]  host_exp [$];
    logic [8:0]  he;

    mem_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_stall(vid_stall),
        .o_vid_valid(vid_valid), .o_vid_dat(vid_dat),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
        .i_host_dat(host_wdat), .o_host_ack(host_ack), .o_host_dat(host_rdat),
        .o_host_err(host_err), .i_font_wp(font_wp),
        .o_mem_cs(mem_cs), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_dat(mem_wdat), .i_mem_dat(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) mem[mem_addr] <= mem_wdat;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (vid_valid) begin
            if (vid_exp.size() == 0) chk("vid_unexpected_valid", 32'(vid_valid), 32'd0);
            else chk("vid_dat", 32'(vid_dat), 32'(vid_exp.pop_front()));
        end else begin
            chk("vid_dat_idle", 32'(vid_dat), 32'd0);
        end
        if (host_ack) begin
            if (host_exp.size() == 0) begin
                chk("host_unexpected_ack", 32'(host_ack), 32'd0);
            end else begin
                he = host_exp.pop_front();
                chk("host_dat", 32'(host_rdat), 32'(he[7:0]));
                chk("host_err", 32'(host_err), 32'(he[8]));
            end
        end else begin
            chk("host_err_idle", 32'(host_err), 32'd0);
            chk("host_dat_idle", 32'(host_rdat), 32'd0);
        end
    end

    task automatic host_txn(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                            input logic [7:0] exp_rd, input logic exp_err,
                            output int ack_c, output logic saw_we);
        host_req  = 1'b1;
        host_we   = we;
        host_addr = addr;
        host_wdat = wd;
        host_exp.push_back({exp_err, (we ? 8'h00 : exp_rd)});
        ack_c  = -1;
        saw_we = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (mem_we) saw_we = 1'b1;
            if (host_ack) begin
                ack_c = cyc;
                break;
            end
        end
        if (ack_c < 0) chk("host_ack_timeout", 32'(host_ack), 32'd1);
        @(posedge clk); #1;
        host_req  = 1'b0;
        host_we   = 1'b0;
        host_addr = 13'h0;
        host_wdat = 8'h0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_vid_stall"}, 32'(vid_stall), 32'd0);
        chk({tag, "_vid_valid"}, 32'(vid_valid), 32'd0);
        chk({tag, "_host_ack"},  32'(host_ack),  32'd0);
        chk({tag, "_mem_cs"},    32'(mem_cs),    32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_dat"},   32'(mem_wdat),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   ack_c, start_c, k, stalls, stall_c;
        logic sw, pushed;

        for (int i = 0; i < 32; i++) mem[13'h1000 + 13'(i)] <= 8'(32'h41 + i);
        mem[13'h0010] <= 8'h3C;
        mem[13'h1100] <= 8'h77;

        // Reset: memory never selected even with a video request present.
        vid_req  = 1'b1;
        vid_addr = 13'h1000;
        @(negedge clk);
        chk("rst_vid_mem_cs", 32'(mem_cs), 32'd0);
        chk("rst_vid_mem_we", 32'(mem_we), 32'd0);
        vid_req  = 1'b0;
        vid_addr = 13'h0;
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Video only: three back-to-back reads, no stall.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin
                vid_req  = 1'b1;
                vid_addr = 13'(32'h1000 + i);
                vid_exp.push_back(8'(32'h41 + i));
            end else begin
                vid_req  = 1'b0;
                vid_addr = 13'h0;
            end
            @(negedge clk);
            chk("vid_only_stall", 32'(vid_stall), 32'd0);
            if (i > 0) chk("vid_only_valid", 32'(vid_valid), 32'd1);
        end
        @(negedge clk);
        chk("vid_only_valid_end", 32'(vid_valid), 32'd0);

        // Host write then readback, video idle.
        @(posedge clk); #1;
        start_c = cyc;
        host_txn(1'b1, 13'h1234, 8'h5A, 8'h00, 1'b0, ack_c, sw);
        chk("host_wr_latency", 32'(ack_c - start_c), 32'd1);
        start_c = cyc;
        host_txn(1'b0, 13'h1234, 8'h00, 8'h5A, 1'b0, ack_c, sw);
        chk("host_rd_latency", 32'(ack_c - start_c), 32'd1);

        // Font write-protect on, then off.
        font_wp = 1'b1;
        host_txn(1'b1, 13'h0010, 8'hFF, 8'h00, 1'b1, ack_c, sw);
        chk("wp_mem_we_blocked", 32'(sw), 32'd0);
        host_txn(1'b0, 13'h0010, 8'h00, 8'h3C, 1'b0, ack_c, sw);
        font_wp = 1'b0;
        host_txn(1'b1, 13'h0010, 8'hFF, 8'h00, 1'b0, ack_c, sw);
        chk("nowp_mem_we", 32'(sw), 32'd1);
        host_txn(1'b0, 13'h0010, 8'h00, 8'hFF, 1'b0, ack_c, sw);

        // Starvation: video every cycle, host read pending from cycle 0.
        k = 0; stalls = 0; stall_c = -1; pushed = 1'b0;
        start_c = cyc;
        fork
            begin
                for (int it = 0; it < 60 && k < 20; it++) begin
                    vid_req  = 1'b1;
                    vid_addr = 13'(32'h1000 + k);
                    if (!pushed) begin
                        vid_exp.push_back(8'(32'h41 + k));
                        pushed = 1'b1;
                    end
                    @(negedge clk);
                    if (vid_stall) begin
                        stalls++;
                        stall_c = cyc;
                    end else begin
                        k++;
                        pushed = 1'b0;
                    end
                    @(posedge clk); #1;
                end
                vid_req  = 1'b0;
                vid_addr = 13'h0;
            end
            host_txn(1'b0, 13'h1001, 8'h00, 8'h42, 1'b0, ack_c, sw);
        join
        chk("starve_ack_cycle", 32'(ack_c - start_c), 32'd16);
        chk("starve_stall_cycle", 32'(stall_c - start_c), 32'd15);
        chk("starve_stall_count", 32'(stalls), 32'd1);
        chk("starve_vid_count", 32'(k), 32'd20);

        // Busy guard: host holds request through and after its ack.
        @(posedge clk); #1;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 13'h1234;
        host_exp.push_back({1'b0, 8'h5A});
        host_exp.push_back({1'b0, 8'h5A});
        @(negedge clk);
        chk("busy_first_grant", 32'(mem_cs), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_ack", 32'(host_ack), 32'd1);
        chk("busy_no_regrant", 32'(mem_cs), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_regrant", 32'(mem_cs), 32'd1);
        @(posedge clk); #1;
        host_req  = 1'b0;
        host_addr = 13'h0;
        @(negedge clk);
        chk("busy_second_ack", 32'(host_ack), 32'd1);

        // Async reset in a host-write grant cycle.
        @(posedge clk); #1;
        host_req  = 1'b1;
        host_we   = 1'b1;
        host_addr = 13'h1100;
        host_wdat = 8'hEE;
        #2;
        chk("rst_pre_mem_cs", 32'(mem_cs), 32'd1);
        chk("rst_pre_mem_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_mem_cs", 32'(mem_cs), 32'd0);
        chk("rst_async_mem_we", 32'(mem_we), 32'd0);
        host_req  = 1'b0;
        host_we   = 1'b0;
        host_addr = 13'h0;
        host_wdat = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_target_unchanged", 32'(mem[13'h1100]), 32'h77);
        chk_outputs_zero("post_rst");
        chk("post_rst_starve_cnt", 32'(dut.starve_cnt_q), 32'd0);

        repeat (3) @(negedge clk);
        chk("vid_queue_drained", 32'(vid_exp.size()), 32'd0);
        chk("host_queue_drained", 32'(host_exp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter in front of the 8 KiB single-port character/font memory (font at 0x0000–0x0FFF, screen at 0x1000–0x1FFF). It shares the memory between the VGA text fetch engine and the host write/readback port (UART/CPU side). The video port has fixed priority, with a bounded-starvation guarantee for the host. An optional write-protect guards the font region against host writes.

## Interface

Parameters:
- AW, 13, memory address width
- DW, 8, data width
- STARVE_MAX, 15, consecutive denied host-pending cycles before the host is forced a slot (1..255)
- FONT_TOP, 'h1000, first address outside the protected font region

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_vid_req  in  1  video read request
- i_vid_addr  in  AW  video read address
- o_vid_stall  out  1  video request not granted this cycle; hold request and address
- o_vid_valid  out  1  video read data valid
- o_vid_dat  out  DW  video read data
- i_host_req  in  1  host request; held with addr/data/we until o_host_ack
- i_host_we  in  1  1 = write, 0 = read
- i_host_addr  in  AW  host address
- i_host_dat  in  DW  host write data
- o_host_ack  out  1  one-cycle transaction-complete pulse
- o_host_dat  out  DW  host read data, valid with o_host_ack on reads
- o_host_err  out  1  pulse with o_host_ack when a write was dropped by protect
- i_font_wp  in  1  1 = drop host writes to addresses < FONT_TOP
- o_mem_cs, o_mem_we  out  1  memory chip select / write enable
- o_mem_addr  out  AW  memory address
- o_mem_dat  out  DW  memory write data
- i_mem_dat  in  DW  memory read data, registered by memory (1-cycle latency)

## Operation

- Each cycle (grant cycle T), the arbiter selects at most one owner: VID, HOST, or NONE. Memory-side outputs are combinational from this selection.
- Host eligible = i_host_req & ~host_busy. host_busy is set at host grant and cleared at the end of the ack cycle. The host is therefore never re-granted during its own ack cycle.
- Selection rule:
  - Forced: starve_cnt == STARVE_MAX and host eligible -> HOST.
  - Else i_vid_req -> VID.
  - Else host eligible -> HOST.
  - Else NONE.
- o_vid_stall = i_vid_req & (owner != VID).
- starve_cnt (8 bit):
  - Increments (saturating at STARVE_MAX) in any cycle where the host is eligible and not granted.
  - Clears to 0 on host grant.
  - Holds otherwise.
- Memory drive:
  - VID: cs=1, we=0, addr=i_vid_addr.
  - HOST read: cs=1, we=0, addr=i_host_addr.
  - HOST write: cs=1, we=~(i_font_wp & (i_host_addr < FONT_TOP)), addr=i_host_addr, dat=i_host_dat.
  - NONE: cs=0, we=0, addr and dat 0.
- Registered tag rd_owner records the owner of each grant, plus a host-write flag and a protect-hit flag, for use at T+1.
- At T+1:
  - Owner VID: o_vid_valid=1, o_vid_dat=i_mem_dat.
  - Owner HOST: o_host_ack=1. On reads, o_host_dat=i_mem_dat. On a protected write, o_host_err=1.
  - o_vid_dat and o_host_dat are 0 when not valid.
- A protected write is still acknowledged. The memory is not written.

## Timing

- Video read latency: 1 cycle from an unstalled request to o_vid_valid. Back-to-back video requests are accepted every cycle.
- Host latency: ack 1 cycle after grant. Minimum host period is 2 cycles (grant, ack). The host drops or changes its request in the cycle after the ack.
- Worst-case host wait under continuous video traffic: STARVE_MAX cycles, then granted on cycle STARVE_MAX+1.
- Worst-case video stall: 1 cycle per forced host slot, at most one stall per STARVE_MAX+2 cycles.
- Reset values: all outputs 0, starve_cnt=0, host_busy=0, rd_owner=NONE.
  - While i_rst_n=0, o_mem_cs and o_mem_we are forced 0 combinationally, so no write occurs.
  - Reset during a pending host transaction discards it. No ack is issued, and the host must re-request after reset.
- Simultaneous request events:
  - Host and video requesting together with starve_cnt < STARVE_MAX: VID wins, counter increments.
  - At STARVE_MAX: HOST wins, video stalls one cycle and is granted next cycle.
- A host request that deasserts before ack is a protocol violation. Behaviour is undefined and the bench does not test it.

## Test plan

- Video only: requests at 0x1000, 0x1001, 0x1002 in consecutive cycles with memory preloaded 0x41/0x42/0x43 -> o_vid_valid high for 3 cycles starting T+1, data 0x41, 0x42, 0x43; o_vid_stall never high.
- Host write then read with video idle, i_font_wp=0: write 0x5A to 0x1234 -> ack at T+1, o_host_err=0; subsequent read of 0x1234 -> ack with o_host_dat=0x5A.
- Starvation: video requesting every cycle, host read pending from cycle 0, STARVE_MAX=15 -> host granted at cycle 15, ack at cycle 16; o_vid_stall=1 only in cycle 15; video data returns uninterrupted in order.
- Write protect: i_font_wp=1, host write 0xFF to 0x0010 (preloaded 0x3C) -> ack with o_host_err=1, o_mem_we stays 0; readback gives 0x3C. Repeat with i_font_wp=0 -> readback gives 0xFF.
- Busy guard: host holds i_host_req high through and after ack -> no second grant in the ack cycle; next grant no earlier than ack cycle +1.
- Async reset mid-transaction: assert i_rst_n=0 in a host-write grant cycle before the clock edge -> o_mem_cs/o_mem_we drop immediately, the target byte is unchanged, and no ack appears. After release, all outputs read 0 and starve_cnt is 0.
